pam_n_slicer: RTL and testbench

Parametrised PAM-N receive slicer, the threshold-based successor to the exact-match PAM-4 decoder. It maps a signed received sample to one of N = 2^BITS_PER_SYMBOL symbols using midpoint thresholds, so noisy or equalised samples decode correctly. It optionally Gray-decodes the symbol, reports the signed decision error, and keeps saturating symbol and over-range statistics. It sits in the Rx path after the channel/equaliser and before symbol-to-bit reassembly.

---
 rtl/pam_pkg.sv | 25 ++
 rtl/pam_sat_counter.sv | 39 +++
 rtl/pam_n_slicer.sv | 149 ++++++++++++++
 tb/tb_pam_n_slicer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pam_pkg.sv
// Shared PAM-N helpers. The Tx mapper and the Rx slicer both use pam_level,
// so transmitted and expected levels cannot drift apart.
package pam_pkg;

  // Number of levels for a given bits-per-symbol.
  function automatic int pam_num_levels(input int bits);
    return 1 << bits;
  endfunction

  // Ideal level of index k: (2k-(N-1))*sep/2. sep is even, so the result is exact.
  function automatic int pam_level(input int k, input int sep, input int bits);
    return ((2 * k - (pam_num_levels(bits) - 1)) * sep) / 2;
  endfunction

  // Decision threshold j, the midpoint between levels j and j+1.
  function automatic int pam_threshold(input int j, input int sep, input int bits);
    return ((2 * j + 2 - pam_num_levels(bits)) * sep) / 2;
  endfunction

  // Binary-reflected Gray code of an index (up to 4 bits per symbol).
  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pam_sat_counter.sv
// Saturating event counter with a synchronous clear that loads the current
// increment, so an event coinciding with the clear is not lost.
module pam_sat_counter
  import pam_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear loads 0/1, otherwise add one unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = WIDTH'(inc_i);
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pam_n_slicer.sv
// PAM-N receive slicer: two-stage pipeline mapping a signed sample to the
// nearest ideal level, with optional Gray mapping, decision error output and
// saturating symbol / over-range statistics.
module pam_n_slicer
  import pam_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 10,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int BITS_PER_SYMBOL   = 2,
  parameter int GRAY_CODE         = 0,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                voltage_level_in_valid,
  input  logic                                clear_stats,
  output logic [BITS_PER_SYMBOL-1:0]          symbol_out,
  output logic signed [SIGNAL_RESOLUTION:0]   error_out,
  output logic                                symbol_out_valid,
  output logic [CNT_WIDTH-1:0]                symbol_count,
  output logic [CNT_WIDTH-1:0]                overrange_count
);

  localparam int N   = pam_num_levels(BITS_PER_SYMBOL);
  localparam int SR  = SIGNAL_RESOLUTION;
  localparam int EW  = SIGNAL_RESOLUTION + 1;
  localparam int BPS = BITS_PER_SYMBOL;

  localparam logic signed [EW-1:0] HALF_SEP = EW'(SYMBOL_SEPERATION / 2);
  localparam logic [BPS-1:0]       K_MAX    = '1;

  // ---------------------------------------------------------------------------
  // Stage 1: sample register and thermometer compare vector
  // ---------------------------------------------------------------------------
  logic signed [31:0] x_in_wide;
  logic [N-2:0]       cmp_d;
  logic [N-2:0]       cmp_q;
  logic signed [SR-1:0] x_q;
  logic               vld1_q;

  // Compare in 32 bits so thresholds never alias into the sample width.
  assign x_in_wide = 32'(voltage_level_in);

  // One comparator per threshold; ties resolve upward via >=.
  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_thr
      localparam int THR = pam_threshold(gi, SYMBOL_SEPERATION, BITS_PER_SYMBOL);
      assign cmp_d[gi] = (x_in_wide >= 32'(THR));
    end
  endgenerate

  // Stage-1 registers; data only loads on a valid sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q    <= '0;
      cmp_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= voltage_level_in_valid;
      if (voltage_level_in_valid) begin
        x_q   <= voltage_level_in;
        cmp_q <= cmp_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: index, symbol mapping, decision error, over-range detection
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0] level_lut [N];
  logic signed [EW-1:0] x_ext;
  logic [BPS-1:0]       k_d;
  logic [BPS-1:0]       sym_d;
  logic signed [EW-1:0] err_d;
  logic                 ovr_d;

  logic [BPS-1:0]       sym_q;
  logic signed [EW-1:0] err_q;
  logic                 vld2_q;

  // Constant table of ideal levels, shared with the encoder via pam_level.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lvl
      assign level_lut[gi] = EW'(pam_level(gi, SYMBOL_SEPERATION, BITS_PER_SYMBOL));
    end
  endgenerate

  assign x_ext = EW'(x_q);

  // Index is the count of thresholds passed; error and over-range follow from it.
  always_comb begin
    k_d = '0;
    for (int j = 0; j < N - 1; j++) begin
      k_d = k_d + BPS'(cmp_q[j]);
    end
    err_d = x_ext - level_lut[k_d];
    if (GRAY_CODE != 0) begin
      sym_d = BPS'(bin2gray(4'(k_d)));
    end else begin
      sym_d = k_d;
    end
    ovr_d = ((k_d == '0)   && (err_d < -HALF_SEP)) ||
            ((k_d == K_MAX) && (err_d >  HALF_SEP));
  end

  // Stage-2 registers; symbol and error hold while no result is produced.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sym_q  <= '0;
      err_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        sym_q <= sym_d;
        err_q <= err_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: counters advance on the same edge that presents the result
  // ---------------------------------------------------------------------------
  pam_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_symbol_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (vld1_q),
    .clr_i   (clear_stats),
    .count_o (symbol_count)
  );

  pam_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_overrange_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (vld1_q & ovr_d),
    .clr_i   (clear_stats),
    .count_o (overrange_count)
  );

  assign symbol_out       = sym_q;
  assign error_out        = err_q;
  assign symbol_out_valid = vld2_q;

endmodule

// File: tb/tb_pam_n_slicer.sv
// Directed bench for pam_n_slicer: default, Gray-coded and 4-bit-counter
// instances share one stimulus stream.
module tb_pam_n_slicer;

  logic              clk;
  logic              rstn;
  logic signed [9:0] vin;
  logic              vld;
  logic              clr;

  logic [1:0]         sym_a, sym_g, sym_c;
  logic signed [10:0] err_a, err_g, err_c;
  logic               ov_a, ov_g, ov_c;
  logic [31:0]        scnt_a, ocnt_a, scnt_g, ocnt_g;
  logic [3:0]         scnt_c, ocnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  pam_n_slicer dut (
    .clk(clk), .rstn(rstn), .voltage_level_in(vin), .voltage_level_in_valid(vld),
    .clear_stats(clr), .symbol_out(sym_a), .error_out(err_a), .symbol_out_valid(ov_a),
    .symbol_count(scnt_a), .overrange_count(ocnt_a));

  pam_n_slicer #(.GRAY_CODE(1)) dut_g (
    .clk(clk), .rstn(rstn), .voltage_level_in(vin), .voltage_level_in_valid(vld),
    .clear_stats(clr), .symbol_out(sym_g), .error_out(err_g), .symbol_out_valid(ov_g),
    .symbol_count(scnt_g), .overrange_count(ocnt_g));

  pam_n_slicer #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rstn(rstn), .voltage_level_in(vin), .voltage_level_in_valid(vld),
    .clear_stats(clr), .symbol_out(sym_c), .error_out(err_c), .symbol_out_valid(ov_c),
    .symbol_count(scnt_c), .overrange_count(ocnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int sym;
    int gsym;
    int err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    vld  = 1'b0;
    clr  = 1'b0;
    vin  = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Stream table entries back-to-back; each result is checked 2 cycles later.
  task automatic run_group(input int start, input int len, input int exp_cnt, input int exp_ovr);
    for (int i = 0; i < len + 2; i++) begin
      step();
      if (i >= 2) begin
        chk($sformatf("vec%0d valid", start + i - 2), int'(ov_a), 1);
        chk($sformatf("vec%0d symbol", start + i - 2), int'(sym_a), tbl[start + i - 2].sym);
        chk($sformatf("vec%0d error", start + i - 2), int'(err_a), tbl[start + i - 2].err);
        chk($sformatf("vec%0d gray", start + i - 2), int'(sym_g), tbl[start + i - 2].gsym);
      end
      if (i < len) begin
        vin = 10'(tbl[start + i].x);
        vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
    end
    chk("symbol_count", int'(scnt_a), exp_cnt);
    chk("overrange_count", int'(ocnt_a), exp_ovr);
  endtask

  initial begin
    // nominal levels
    tbl[0]  = '{-84, 0, 0,  0};
    tbl[1]  = '{-28, 1, 1,  0};
    tbl[2]  = '{ 28, 2, 3,  0};
    tbl[3]  = '{ 84, 3, 2,  0};
    // threshold sweep
    tbl[4]  = '{-57, 0, 0,  27};
    tbl[5]  = '{-56, 1, 1, -28};
    tbl[6]  = '{ -1, 1, 1,  27};
    tbl[7]  = '{  0, 2, 3, -28};
    tbl[8]  = '{ 55, 2, 3,  27};
    tbl[9]  = '{ 56, 3, 2, -28};
    // outer-level over-range
    tbl[10] = '{ 112, 3, 2,   28};
    tbl[11] = '{ 113, 3, 2,   29};
    tbl[12] = '{-200, 0, 0, -116};

    rstn = 1'b0;
    vld  = 1'b0;
    clr  = 1'b0;
    vin  = '0;
    do_reset();

    chk("reset valid", int'(ov_a), 0);
    chk("reset symbol", int'(sym_a), 0);
    chk("reset error", int'(err_a), 0);
    chk("reset symbol_count", int'(scnt_a), 0);
    chk("reset overrange_count", int'(ocnt_a), 0);

    run_group(0, 4, 4, 0);
    do_reset();
    run_group(4, 6, 6, 0);
    do_reset();
    run_group(10, 3, 3, 2);

    // Valid gap 1,0,1 reappears delayed; symbol holds through the gap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) begin
        chk("gap out0 valid", int'(ov_a), 1);
        chk("gap out0 symbol", int'(sym_a), 2);
      end
      if (i == 3) begin
        chk("gap out1 valid", int'(ov_a), 0);
        chk("gap hold symbol", int'(sym_a), 2);
      end
      if (i == 4) begin
        chk("gap out2 valid", int'(ov_a), 1);
        chk("gap out2 symbol", int'(sym_a), 1);
      end
      case (i)
        0: begin vin = 10'sd28;  vld = 1'b1; end
        1: begin vin = 10'sd84;  vld = 1'b0; end
        2: begin vin = -10'sd28; vld = 1'b1; end
        default: vld = 1'b0;
      endcase
    end

    // clear_stats while the third symbol completes counts that symbol.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 3) begin
        chk("pre-clear symbol_count", int'(scnt_a), 2);
        clr = 1'b1;
      end
      if (i == 4) begin
        chk("clear symbol_count", int'(scnt_a), 1);
        chk("clear overrange_count", int'(ocnt_a), 0);
        clr = 1'b0;
      end
      if (i < 3) begin
        vin = 10'sd28;
        vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
    end

    // Reset asserted with samples in flight: nothing emerges afterwards.
    step();
    vin = 10'sd84;
    vld = 1'b1;
    step();
    vin = 10'sd60;
    rstn = 1'b0;
    #1;
    chk("midrst symbol", int'(sym_a), 0);
    chk("midrst symbol_count", int'(scnt_a), 0);
    vld = 1'b0;
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post-rst valid c%0d", i), int'(ov_a), 0);
    end
    chk("post-rst symbol", int'(sym_a), 0);
    chk("post-rst error", int'(err_a), 0);
    chk("post-rst symbol_count", int'(scnt_a), 0);

    // 20 over-range samples: 4-bit counters hold at 15, 32-bit reach 20.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      vin = 10'sd200;
      vld = 1'b1;
    end
    step();
    vld = 1'b0;
    repeat (3) step();
    chk("sat symbol_count w4", int'(scnt_c), 15);
    chk("sat overrange_count w4", int'(ocnt_c), 15);
    chk("sat symbol_count w32", int'(scnt_a), 20);
    chk("sat overrange_count w32", int'(ocnt_a), 20);
    chk("sat error", int'(err_a), 116);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
